seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
Downstream display stage for Counter_Main. It consumes the three BCD time digits (M:SS) and drives a 3-digit, common-anode, time-multiplexed seven-segment display. The block contains:
- a refresh prescaler,
- a digit-scan state machine with an anti-ghosting guard cycle,
- a per-frame digit snapshot, so a displayed frame never mixes old and new digits.

Parameters:
- REFRESH_DIV, 50000: clocks per digit slot, minimum 4. A scan tick is generated every REFRESH_DIV clocks.
- BLINK_TICKS, 256: scan ticks per blink half-period. Used only with SEG7_BLINK_EN.

Ports:
- Clk, input, 1: system clock.
- nReset, input, 1: asynchronous active-low reset.
- DisplayEnable, input, 1: 1 = scan the display; 0 = all digits dark.
- S1, input, 4: BCD seconds-ones digit.
- S2, input, 4: BCD seconds-tens digit.
- S3, input, 4: BCD minutes digit.
- Blink, input, 1: request blinking of the whole display (e.g. at terminal count). Ignored without SEG7_BLINK_EN.
- Seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- Dp, output, 1: decimal point, active-low. Used as the M:SS separator.
- An, output, 3: digit anodes, active-low. An[0]=S1, An[1]=S2, An[2]=S3.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on nReset; all state is cleared immediately on assertion.
- Reset values:
  - Seg=7'h7F, Dp=1, An=3'b111.
  - Prescaler=0, digit index=0, FSM=IDLE, snapshot registers=0, blink phase=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick=1 for one clock when count==REFRESH_DIV-1.
  - Held at 0 while the FSM is in IDLE.
- FSM states: IDLE, GUARD, SHOW.
  - IDLE: An=111, Seg=7F, Dp=1. When DisplayEnable=1, go to GUARD with digit index=0 on the next edge.
  - GUARD: exactly 1 clock, all outputs off. Then go to SHOW.
  - SHOW: the selected digit is driven. On tick, advance the index 0→1→2→0 and go to GUARD.
  - DisplayEnable=0 in any state forces IDLE on the next edge. Outputs are dark in the cycle after that edge.
- Snapshot:
  - S1, S2 and S3 are all captured together on the GUARD cycle where the index is 0.
  - The digits of one frame are therefore coherent. Input changes mid-frame appear in the next frame.
- Output registration:
  - All outputs are registered, so An, Seg and Dp change on the same edge.
  - Latency: the first SHOW begins 2 clocks after DisplayEnable is sampled high.
- Decode: 0–9 use the standard patterns, e.g. 0=7'h40, 1=7'h79, 5=7'h12, 8=7'h00. Invalid BCD (10–15) displays a dash: Seg=7'h3F (segment g only).
- Dp: 0 only while An=3'b011 (the minutes digit is shown); 1 otherwise.
- Simultaneous events:
  - If reset and tick coincide, reset wins.
  - If DisplayEnable falls on a tick edge, the FSM goes to IDLE and the index is reset to 0.

Optional Feature:
SEG7_BLINK_EN
- Defined:
  - A blink counter counts scan ticks and toggles the blink phase every BLINK_TICKS ticks.
  - While Blink=1 and phase=1, SHOW drives An=111, Seg=7F, Dp=1. Scanning and snapshots continue during this dark phase.
  - When Blink falls, the phase is cleared and the display is lit on the next SHOW.
- Undefined: Blink is ignored, no blink counter is synthesized, and the port remains present.

Decomposition:
- seg7_pkg contains:
  - FSM state encoding (IDLE, GUARD, SHOW).
  - Segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - Anode constants AN_OFF, AN_D0..AN_D2.
- Sub-module bcd_to_seg7: combinational 4-bit BCD to 7-bit active-low decoder, including dash handling.

Test Plan (all scenarios with REFRESH_DIV=4, BLINK_TICKS=2):
1. Reset mid-scan, then release with DisplayEnable=0 → outputs Seg=7F, An=111, Dp=1 immediately on nReset low and held after release.
2. S3=1, S2=2, S1=5, DisplayEnable=1:
   - After 2 clocks: An=110, Seg=7'h12.
   - Then GUARD: An=111 for 1 clock.
   - Then An=101, Seg=7'h24.
   - Then An=011, Seg=7'h79, Dp=0.
   - Sequence repeats.
3. Change S1 from 5 to 6 while the S2 digit is shown → current frame still uses the old snapshot. S1's slot shows 6 (7'h02) only after the next index-0 GUARD.
4. S2=4'hC → the An=101 slot shows Seg=7'h3F.
5. Drop DisplayEnable during SHOW → all dark on the following edge. Re-assert → restart at the S1 digit after 2 clocks.
6. With SEG7_BLINK_EN defined and Blink=1 → display is dark for 2 scan ticks, lit for 2, alternating. Without the macro, the same stimulus produces no dark slots.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the 3-digit seven-segment
//                scan driver: scan FSM state encoding, active-low segment
//                patterns {g,f,e,d,c,b,a} and active-low anode selects.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } scanState_t;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [2:0] AN_OFF = 3'b111;
  localparam logic [2:0] AN_D0  = 3'b110;
  localparam logic [2:0] AN_D1  = 3'b101;
  localparam logic [2:0] AN_D2  = 3'b011;

  // Digit index 0/1/2 -> anode select (seconds-ones, seconds-tens, minutes).
  function automatic logic [2:0] anodeFor(input logic [1:0] idx);
    case (idx)
      2'd0:    return AN_D0;
      2'd1:    return AN_D1;
      default: return AN_D2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD to active-low seven-segment decoder.
//                Codes 10..15 are not valid BCD and render as a dash.
//  Ports       : bcd [3:0] in  - BCD digit
//                seg [6:0] out - segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for a 3-digit common-anode display
//                showing M:SS. A refresh prescaler paces the digit slots; each
//                slot opens with a one-clock all-dark guard cycle to prevent
//                ghosting. All three digits are snapshotted together at the
//                start of each frame so a frame never mixes old/new digits.
//  Options     : SEG7_BLINK_EN - when defined, Blink=1 alternately darkens
//                the display for BLINK_TICKS scan ticks.
//  Ports       : Clk            in   system clock
//                nReset         in   asynchronous active-low reset
//                DisplayEnable  in   1 = scan, 0 = all digits dark
//                S1/S2/S3 [3:0] in   seconds-ones / seconds-tens / minutes
//                Blink          in   blink request (needs SEG7_BLINK_EN)
//                Seg [6:0]      out  segments {g..a}, active-low
//                Dp             out  decimal point (M:SS separator), active-low
//                An [2:0]       out  digit anodes, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 256
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       DisplayEnable,
  input  logic [3:0] S1,
  input  logic [3:0] S2,
  input  logic [3:0] S3,
  input  logic       Blink,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [2:0] An
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] C_PRE_MAX = PW'(REFRESH_DIV - 1);

  scanState_t    r_state;
  logic [PW-1:0] r_prescaleCnt;
  logic [1:0]    r_digitIdx;
  logic [3:0]    r_snapS1;
  logic [3:0]    r_snapS2;
  logic [3:0]    r_snapS3;

  logic          w_tick;
  logic          w_blinkDark;
  logic [3:0]    w_curBcd;
  logic [6:0]    w_curSeg;

  // Prescaler sits at 0 in IDLE and is 0 in every GUARD cycle, so with
  // REFRESH_DIV >= 4 the tick can only land in SHOW.
  assign w_tick = (r_prescaleCnt == C_PRE_MAX);

  // Digit for the slot about to open. On the frame-start guard the snapshot
  // is being loaded on this same edge, so digit 0 comes straight from S1.
  always_comb begin
    w_curBcd = r_snapS3;
    case (r_digitIdx)
      2'd0:    w_curBcd = (r_state == ST_GUARD) ? S1 : r_snapS1;
      2'd1:    w_curBcd = r_snapS2;
      default: w_curBcd = r_snapS3;
    endcase
  end

  bcd_to_seg7 u_decode (
    .bcd (w_curBcd),
    .seg (w_curSeg)
  );

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] C_BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] r_blinkCnt;
  logic          r_blinkPhase;

  // Counts scan ticks only while Blink is requested; dropping Blink restarts
  // the pattern in the lit phase.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (!Blink) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (DisplayEnable && (r_state == ST_SHOW) && w_tick) begin
      if (r_blinkCnt == C_BLINK_MAX) begin
        r_blinkCnt   <= '0;
        r_blinkPhase <= ~r_blinkPhase;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
    end
  end

  assign w_blinkDark = Blink & r_blinkPhase;
`else
  // Constant 0: blinking is not built, but the port and parameter stay bound.
  assign w_blinkDark = Blink & (BLINK_TICKS < 0);
`endif

  // Outputs are loaded from next-state values so An/Seg/Dp switch together
  // on the edge that enters or leaves SHOW, and are held through SHOW.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state       <= ST_IDLE;
      r_prescaleCnt <= '0;
      r_digitIdx    <= 2'd0;
      r_snapS1      <= 4'd0;
      r_snapS2      <= 4'd0;
      r_snapS3      <= 4'd0;
      Seg           <= SEG_OFF;
      Dp            <= 1'b1;
      An            <= AN_OFF;
    end else if (!DisplayEnable) begin
      r_state       <= ST_IDLE;
      r_prescaleCnt <= '0;
      r_digitIdx    <= 2'd0;
      Seg           <= SEG_OFF;
      Dp            <= 1'b1;
      An            <= AN_OFF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state       <= ST_GUARD;
          r_prescaleCnt <= '0;
          r_digitIdx    <= 2'd0;
          Seg           <= SEG_OFF;
          Dp            <= 1'b1;
          An            <= AN_OFF;
        end
        ST_GUARD: begin
          r_state       <= ST_SHOW;
          r_prescaleCnt <= r_prescaleCnt + 1'b1;
          if (r_digitIdx == 2'd0) begin
            r_snapS1 <= S1;
            r_snapS2 <= S2;
            r_snapS3 <= S3;
          end
          if (w_blinkDark) begin
            Seg <= SEG_OFF;
            Dp  <= 1'b1;
            An  <= AN_OFF;
          end else begin
            Seg <= w_curSeg;
            Dp  <= (r_digitIdx == 2'd2) ? 1'b0 : 1'b1;
            An  <= anodeFor(r_digitIdx);
          end
        end
        ST_SHOW: begin
          if (w_tick) begin
            r_state       <= ST_GUARD;
            r_prescaleCnt <= '0;
            r_digitIdx    <= (r_digitIdx == 2'd2) ? 2'd0 : r_digitIdx + 2'd1;
            Seg           <= SEG_OFF;
            Dp            <= 1'b1;
            An            <= AN_OFF;
          end else begin
            r_prescaleCnt <= r_prescaleCnt + 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_prescaleCnt <= '0;
          r_digitIdx    <= 2'd0;
          Seg           <= SEG_OFF;
          Dp            <= 1'b1;
          An            <= AN_OFF;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
